// File: rtl/mem_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port synchronous memory.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed priority.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          port_q, port_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          grant1;
    logic          idle_ok;
    logic          accept;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    // On a tie the port that did not win last time is served.
    assign grant1 = req1_valid & (~req0_valid | ~last_q);
`else
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign idle_ok     = (state_q == IDLE) & ~rst;
    assign req0_ready  = idle_ok & req0_valid & ~grant1;
    assign req1_ready  = idle_ok & grant1;
    assign accept      = req0_ready | req1_ready;

    assign mem_address = addr_q;
    assign mem_data    = wdata_q;
    assign mem_we      = (state_q == ISSUE) & we_q;
    assign busy        = (state_q != IDLE);
    assign req0_rvalid = (state_q == RESP) & ~port_q;
    assign req1_rvalid = (state_q == RESP) & port_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    port_d  = grant1;
                    we_d    = grant1 ? req1_we    : req0_we;
                    addr_d  = grant1 ? req1_addr  : req0_addr;
                    wdata_d = grant1 ? req1_wdata : req0_wdata;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant1;
`endif
                end
            end
            ISSUE: state_d = we_q ? IDLE : WAIT;
            WAIT: begin
                state_d = RESP;
                if (port_q) begin
                    rdata1_d = mem_data_out;
                end else begin
                    rdata0_d = mem_data_out;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and read scoreboard.
// Tie-break expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data, mem_data_out;
    logic          mem_we, busy;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ref_mem [256];

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_address] <= mem_data;
        mem_data_out <= ram[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (req0_rvalid) begin
            chk("p0_rvalid_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) chk("p0_rdata", req0_rdata, q0.pop_front());
        end
        if (req1_rvalid) begin
            chk("p1_rvalid_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) chk("p1_rdata", req1_rdata, q1.pop_front());
        end
        if (req0_rvalid && req1_rvalid) chk("rvalid_both", 1, 0);
    end

    task automatic set_req(input bit p, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Called just after a falling edge; returns at the ISSUE-cycle falling edge.
    time acc_t;
    task automatic do_cmd(input bit p, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 0;
        set_req(p, 1'b1, we, a, d);
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if ((!p && req0_ready) || (p && req1_ready)) begin
                @(posedge clk);
                acc_t = $time;
                if (we) ref_mem[a] = d;
                else if (p) q1.push_back(ref_mem[a]);
                else q0.push_back(ref_mem[a]);
                #1;
                set_req(p, 1'b0, we, a, d);
                @(negedge clk);
                chk("issue_busy", busy, 1);
                chk("issue_we", mem_we, we);
                chk("issue_addr", mem_address, a);
                if (we) chk("issue_data", mem_data, d);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("accept_in_time", done, 1);
        if (!done) set_req(p, 1'b0, we, a, d);
    endtask

    task automatic check_read(input bit p);
        @(negedge clk);
        chk("wait_rvalid", p ? req1_rvalid : req0_rvalid, 0);
        chk("wait_busy", busy, 1);
        @(negedge clk);
        chk("resp_rvalid", p ? req1_rvalid : req0_rvalid, 1);
        chk("resp_other_rvalid", p ? req0_rvalid : req1_rvalid, 0);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("reach_idle", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        time prev_t;
        int  we_save;

        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);
        chk("rst_rvalid", {req0_rvalid, req1_rvalid}, 0);
        rst = 1'b0;
        req0_valid = 1'b0;

        // Eight back-to-back writes, one every two cycles.
        d = 1;
        prev_t = 0;
        for (int i = 0; i < 8; i++) begin
            do_cmd(0, 1'b1, AW'(i), d);
            if (i > 0) chk("write_spacing", 32'(acc_t - prev_t), 20);
            prev_t = acc_t;
            d = d * 10;
        end
        @(negedge clk);
        chk("post_write_we", mem_we, 0);
        chk("post_write_busy", busy, 0);
        chk("hold_addr", mem_address, 7);
        chk("hold_data", mem_data, 10000000);
        #1 chk("we_pulses", we_cnt, 8);

        // Write then read back on port 1.
        do_cmd(0, 1'b1, 8'd5, 100000);
        do_cmd(1, 1'b0, 8'd5, '0);
        check_read(1);

        // Tie: p0 writes addr5, p1 reads addr5; p0 then keeps valid high.
        wait_idle();
        set_req(0, 1'b1, 1'b1, 8'd5, 102);
        set_req(1, 1'b1, 1'b0, 8'd5, '0);
        #1;
        chk("tie1_ready0", req0_ready, 1);
        chk("tie1_ready1", req1_ready, 0);
        @(posedge clk);
        ref_mem[5] = 102;
        #1 set_req(0, 1'b1, 1'b1, 8'd6, 7);
        wait_idle();
`ifdef MEM_ARB_RR_EN
        chk("tie2_ready0", req0_ready, 0);
        chk("tie2_ready1", req1_ready, 1);
        @(posedge clk);
        q1.push_back(ref_mem[5]);
        #1 req1_valid = 1'b0;
        wait_idle();
        chk("after_rr_ready0", req0_ready, 1);
        @(posedge clk);
        ref_mem[6] = 7;
        #1 req0_valid = 1'b0;
`else
        chk("tie2_ready0", req0_ready, 1);
        chk("p1_starved", req1_ready, 0);
        @(posedge clk);
        ref_mem[6] = 7;
        #1 req0_valid = 1'b0;
        wait_idle();
        chk("p1_late_ready", req1_ready, 1);
        chk("p0_late_ready", req0_ready, 0);
        @(posedge clk);
        q1.push_back(ref_mem[5]);
        #1 req1_valid = 1'b0;
`endif
        wait_idle();
        #1 chk("tie_drained", q1.size(), 0);

        // p0 raises then withdraws a write while the arbiter is busy.
        we_save = we_cnt;
        do_cmd(1, 1'b0, 8'd0, '0);
        set_req(0, 1'b1, 1'b1, 8'd7, 32'hDEAD);
        #1 chk("busy_no_ready0", req0_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_idle();
        #1 chk("cancel_no_write", we_cnt, we_save);

        // Read addr7 (must be untouched), then reset in WAIT of a read.
        do_cmd(0, 1'b0, 8'd7, '0);
        check_read(0);
        wait_idle();
        do_cmd(0, 1'b0, 8'd3, '0);
        q0.delete();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'd3, '0);
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_rvalid0", req0_rvalid, 0);
        chk("mid_rst_rdata0", req0_rdata, 0);
        chk("mid_rst_rdata1", req1_rdata, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_ready0", req0_ready, 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid0", req0_rvalid, 0);

        // After reset p0 wins the tie; p1 reads the new value back.
        set_req(0, 1'b1, 1'b1, 8'd3, 1000);
        set_req(1, 1'b1, 1'b0, 8'd3, '0);
        #1;
        chk("rst_tie_ready0", req0_ready, 1);
        chk("rst_tie_ready1", req1_ready, 0);
        @(posedge clk);
        ref_mem[3] = 1000;
        #1 req0_valid = 1'b0;
        wait_idle();
        chk("raw_ready1", req1_ready, 1);
        @(posedge clk);
        q1.push_back(ref_mem[3]);
        #1 req1_valid = 1'b0;
        wait_idle();
        #1;
        chk("raw_rdata1", req1_rdata, 1000);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
